// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types and constants for the host-side transmitter and receiver.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} ps2_tx_state_t;
  localparam int PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, run-length glitch filter and falling-edge strobe for one PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic r_s1, r_s2, r_level, r_fall;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_level <= 1'b1;
      r_fall <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_line;
      r_s2 <= r_s1;
      r_fall <= 1'b0;
      // the filtered level only follows after FILTER_LEN consecutive differing samples
      if (r_s2 == r_level) r_cnt <= '0;
      else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_s2;
        r_fall <= r_level;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_level = r_level;
  assign o_fall = r_fall;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter (inhibit, request-to-send, 11-bit frame, ACK check).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NW = $clog2(PS2_FRAME_BITS);
  ps2_tx_state_t r_state, w_next;
  logic [9:0] r_shreg;
  logic [NW-1:0] r_n;
  logic [IW-1:0] r_inh;
  logic [TW-1:0] r_to;
  logic r_data_oe;
  logic w_clk, w_clk_fall, w_data, w_data_fall_unused, w_to_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk_100MHz), .rst(rst), .i_line(ps2_clk_in), .o_level(w_clk), .o_fall(w_clk_fall)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk_100MHz), .rst(rst), .i_line(ps2_data_in), .o_level(w_data), .o_fall(w_data_fall_unused)
  );

  assign w_to_hit = r_to == TW'(TIMEOUT_CYCLES);

  always_comb begin
    w_next = r_state;
    done = 1'b0;
    err = 1'b0;
    case (r_state)
      IDLE: w_next = tx_valid ? INHIBIT : IDLE;
      INHIBIT: w_next = (r_inh == IW'(INHIBIT_CYCLES - 1)) ? REQ : INHIBIT;
      REQ: w_next = SHIFT;
      SHIFT: begin
        err = w_to_hit;
        w_next = w_to_hit ? IDLE : (w_clk_fall && r_n == NW'(PS2_FRAME_BITS - 2)) ? ACK : SHIFT;
      end
      ACK: begin
        // device ACK is data held low at the eleventh falling clock
        err = w_to_hit || (w_clk_fall && w_data);
        w_next = err ? IDLE : w_clk_fall ? WAIT_IDLE : ACK;
      end
      WAIT_IDLE: begin
        err = w_to_hit;
        done = !w_to_hit && w_clk && w_data;
        w_next = (err || done) ? IDLE : WAIT_IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_n <= '0;
      r_inh <= '0;
      r_to <= '0;
      r_data_oe <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && tx_valid) begin
        r_shreg <= {1'b1, ps2_odd_parity(tx_data), tx_data};
        r_n <= '0;
        r_inh <= '0;
      end
      if (r_state == INHIBIT && r_inh != IW'(INHIBIT_CYCLES)) r_inh <= r_inh + 1'b1;
      if (r_state == INHIBIT) r_data_oe <= 1'b1;
      if (r_state == SHIFT && w_clk_fall) begin
        r_data_oe <= ~r_shreg[0];
        r_shreg <= {1'b0, r_shreg[9:1]};
        if (r_n != NW'(PS2_FRAME_BITS - 1)) r_n <= r_n + 1'b1;
      end
      if (r_state == REQ || w_clk_fall) r_to <= '0;
      else if (!w_to_hit) r_to <= r_to + 1'b1;
    end
  end

  assign tx_ready = r_state == IDLE;
  assign busy = !tx_ready;
  assign ps2_clk_oe = r_state == INHIBIT || r_state == REQ;
  assign ps2_data_oe = r_state == REQ || (r_state == SHIFT && r_data_oe);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a clocking device model and a bit-level scoreboard.
module tb_ps2_host_tx;
  localparam int IC = 20, TC = 500, FL = 2, HALF = 20;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  wire line_clk = dev_clk & ~ps2_clk_oe;
  wire line_data = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TC), .FILTER_LEN(FL)) dut (
    .clk_100MHz(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .err(err), .ps2_clk_in(line_clk), .ps2_data_in(line_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, run = 0, last_run = 0, t_shift = 0, t_err = 0;
  logic prev_oe = 1'b0, err_d = 1'b0;
  logic [2:0] after_err = '0;
  bit exp_q[$];

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (ps2_clk_oe) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (prev_oe && !ps2_clk_oe) t_shift = cyc;
    if (err) t_err = cyc;
    if (err_d) after_err = {ps2_clk_oe, ps2_data_oe, tx_ready};
    err_d = err;
    prev_oe = ps2_clk_oe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit push);
    int t = 0, ones = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_send", tx_ready, 1);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("clk_oe_after_accept", {ps2_clk_oe, tx_ready}, 2'b10);
    if (push) begin
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(d[i]);
        ones += int'(d[i]);
      end
      exp_q.push_back(ones % 2 == 0);
      exp_q.push_back(1'b1);
    end
  endtask

  task automatic sample(input string tag);
    bit e;
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else begin
      e = exp_q.pop_front();
      check(tag, line_data, e);
    end
  endtask

  task automatic device(input int falls, input bit ack);
    int t = 0;
    while (!(ps2_clk_oe == 1'b0 && line_data == 1'b0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rts_seen", t < 2000, 1);
    repeat (HALF) @(negedge clk);
    sample("start");
    for (int k = 1; k <= falls; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      sample(k == 9 ? "parity" : k == 10 ? "stop" : $sformatf("bit%0d", k - 1));
      repeat (HALF) @(negedge clk);
    end
    if (falls == 10) begin
      dev_data = !ack;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      dev_data = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int d0, input string tag);
    int t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check(tag, done_cnt - d0, 1);
    check({tag, "_ready"}, tx_ready, 1);
  endtask

  initial begin
    int d0, e0, t;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe}, 6'b100000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // 1: set-LED command with ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED, 1);
    device(10, 1);
    wait_done(d0, "ed_done");
    check("ed_no_err", err_cnt - e0, 0);
    check("ed_clk_oe_len", last_run, IC + 1);
    check("ed_sb_drained", exp_q.size(), 0);
    // 2: parity boundaries
    d0 = done_cnt;
    send(8'h01, 1);
    device(10, 1);
    wait_done(d0, "x01_done");
    d0 = done_cnt;
    send(8'hFF, 1);
    device(10, 1);
    wait_done(d0, "xff_done");
    // 3: missing ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C, 1);
    device(10, 0);
    repeat (5) @(negedge clk);
    check("nack_err", err_cnt - e0, 1);
    check("nack_no_done", done_cnt - d0, 0);
    check("nack_release", after_err, 3'b001);
    // 4: device never clocks
    e0 = err_cnt;
    send(8'h55, 0);
    t = 0;
    while (!err && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("to_err", err_cnt - e0, 1);
    check("to_latency", t_err - t_shift, TC);
    check("to_release", after_err, 3'b001);
    // 5: reset during data bit 4 (bit 4 of 0x86 is 0, so data is being pulled low)
    send(8'h86, 1);
    device(5, 1);
    check("pre_rst_data_oe", ps2_data_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    send(8'hF3, 1);
    device(10, 1);
    wait_done(d0, "f3_done");
    // 6: request while busy is dropped
    d0 = done_cnt;
    send(8'h5C, 1);
    repeat (3) @(negedge clk);
    check("busy_during_frame", busy, 1);
    tx_data = 8'hAA;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    device(10, 1);
    wait_done(d0, "busy_done");
    repeat (100) @(negedge clk);
    check("busy_single_done", done_cnt - d0, 1);
    check("busy_no_second_frame", {ps2_clk_oe, tx_ready}, 2'b01);
    check("busy_sb_drained", exp_q.size(), 0);
    check("done_err_exclusive", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
